// File: rtl/ifm_pkg.sv
// Shared types and constants for the instruction fetch memory.
package ifm_pkg;

    // Operating mode of the program memory.
    typedef enum logic [1:0] {
        IFM_LOAD  = 2'd0,
        IFM_RUN   = 2'd1,
        IFM_DRAIN = 2'd2
    } ifm_state_t;

    // Response queue depth and the width of its occupancy counter.
    localparam int unsigned IFM_QDEPTH = 2;
    localparam int unsigned IFM_CNT_W  = 2;

endpackage

// File: rtl/ifm_rsp_queue.sv
// Two-entry shift FIFO of fetch responses {err, data}; entry 0 is the head.
// Unused entries are kept at zero so the head reads as 0 whenever empty.
module ifm_rsp_queue
    import ifm_pkg::*;
#(
    parameter int unsigned W = 17
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 push_i,
    input  logic [W-1:0]         push_data_i,
    input  logic                 pop_i,
    output logic [W-1:0]         head_o,
    output logic                 valid_o,
    output logic [IFM_CNT_W-1:0] count_o,
    output logic [IFM_CNT_W-1:0] count_nxt_o
);

    logic [W-1:0]         e0_q, e0_d;
    logic [W-1:0]         e1_q, e1_d;
    logic [IFM_CNT_W-1:0] cnt_q, cnt_d;
    logic                 valid_q;
    logic                 push_ok;
    logic                 pop_ok;

    // Next-state of the entries and occupancy; guards ignore push-when-full and pop-when-empty.
    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        cnt_d   = cnt_q;
        pop_ok  = pop_i && (cnt_q != '0);
        push_ok = push_i && ((cnt_q < IFM_CNT_W'(IFM_QDEPTH)) || pop_ok);
        case ({push_ok, pop_ok})
            2'b10: begin
                if (cnt_q == '0) e0_d = push_data_i;
                else             e1_d = push_data_i;
                cnt_d = cnt_q + IFM_CNT_W'(1);
            end
            2'b01: begin
                e0_d  = (cnt_q == IFM_CNT_W'(2)) ? e1_q : '0;
                e1_d  = '0;
                cnt_d = cnt_q - IFM_CNT_W'(1);
            end
            2'b11: begin
                if (cnt_q == IFM_CNT_W'(2)) begin
                    e0_d = e1_q;
                    e1_d = push_data_i;
                end else begin
                    e0_d = push_data_i;
                end
            end
            default: ;
        endcase
    end

    // Queue registers; reset drops anything in flight.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            e0_q    <= '0;
            e1_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            cnt_q   <= cnt_d;
            valid_q <= (cnt_d != '0);
        end
    end

    assign head_o      = e0_q;
    assign valid_o     = valid_q;
    assign count_o     = cnt_q;
    assign count_nxt_o = reset_i ? '0 : cnt_d;

endmodule

// File: rtl/instr_fetch_mem.sv
// Program memory for the 6502 fetch path: loaded word-by-word in LOAD mode,
// read through a valid/ready request port with a 2-deep response queue in RUN mode.
module instr_fetch_mem
    import ifm_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              run_i,
    output logic              mode_run_o,
    input  logic              ld_en_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [DATA_W-1:0] ld_data_i,
    output logic              ld_err_o,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_err_o
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned QW    = DATA_W + 1;

    logic [DATA_W-1:0]    mem_q [DEPTH];

    ifm_state_t           state_q, state_d;
    logic                 mode_run_q, mode_run_d;
    logic                 req_ready_q, req_ready_d;
    logic                 ld_err_q, ld_err_d;

    logic                 ld_in_range;
    logic                 req_in_range;
    logic [IDX_W-1:0]     ld_idx;
    logic [IDX_W-1:0]     req_idx;
    logic [DATA_W-1:0]    rd_word;
    logic                 push;
    logic                 pop;
    logic [QW-1:0]        head;
    logic                 q_valid;
    logic [IFM_CNT_W-1:0] q_count;
    logic [IFM_CNT_W-1:0] q_count_nxt;

    // Range checks at full address width so addresses at or above DEPTH never alias.
    always_comb begin
        ld_in_range  = {1'b0, ld_addr_i}  < (ADDR_W+1)'(DEPTH);
        req_in_range = {1'b0, req_addr_i} < (ADDR_W+1)'(DEPTH);
        ld_idx       = ld_addr_i[IDX_W-1:0];
        req_idx      = req_addr_i[IDX_W-1:0];
        rd_word      = req_in_range ? mem_q[req_idx] : '0;
        push         = req_valid_i && req_ready_q;
        pop          = q_valid && rsp_ready_i;
    end

    // Program store; not cleared by reset, written only in LOAD with an in-range address.
    always_ff @(posedge clk_i) begin
        if (!reset_i && ld_en_i && (state_q == IFM_LOAD) && ld_in_range) begin
            mem_q[ld_idx] <= ld_data_i;
        end
    end

    ifm_rsp_queue #(.W(QW)) u_rsp_queue (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_i      (push),
        .push_data_i ({!req_in_range, rd_word}),
        .pop_i       (pop),
        .head_o      (head),
        .valid_o     (q_valid),
        .count_o     (q_count),
        .count_nxt_o (q_count_nxt)
    );

    // Mode FSM next state plus next values of the registered status outputs.
    always_comb begin
        state_d     = state_q;
        mode_run_d  = 1'b0;
        req_ready_d = 1'b0;
        ld_err_d    = 1'b0;
        case (state_q)
            IFM_LOAD:  if (run_i) state_d = IFM_RUN;
            IFM_RUN:   if (!run_i) state_d = IFM_DRAIN;
            IFM_DRAIN: begin
                if (run_i)                     state_d = IFM_RUN;
                else if (q_count == '0)        state_d = IFM_LOAD;
            end
            default:   state_d = IFM_LOAD;
        endcase
        mode_run_d  = (state_d == IFM_RUN);
        req_ready_d = (state_d == IFM_RUN) && (q_count_nxt < IFM_CNT_W'(IFM_QDEPTH));
        ld_err_d    = ld_en_i && ((state_q != IFM_LOAD) || !ld_in_range);
    end

    // State and status registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IFM_LOAD;
            mode_run_q  <= 1'b0;
            req_ready_q <= 1'b0;
            ld_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_run_q  <= mode_run_d;
            req_ready_q <= req_ready_d;
            ld_err_q    <= ld_err_d;
        end
    end

    assign mode_run_o  = mode_run_q;
    assign req_ready_o = req_ready_q;
    assign ld_err_o    = ld_err_q;
    assign rsp_valid_o = q_valid;
    assign rsp_data_o  = head[DATA_W-1:0];
    assign rsp_err_o   = head[DATA_W];

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed bench for instr_fetch_mem: load, fetch, backpressure, range errors, drain, reset.
module tb_instr_fetch_mem;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned ADDR_W = 16;

    logic              clk;
    logic              reset;
    logic              run;
    logic              mode_run;
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_err;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] prog [4];

    instr_fetch_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .run_i       (run),
        .mode_run_o  (mode_run),
        .ld_en_i     (ld_en),
        .ld_addr_i   (ld_addr),
        .ld_data_i   (ld_data),
        .ld_err_o    (ld_err),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .rsp_err_o   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        prog[0] = 16'hF00F;
        prog[1] = 16'h1A2B;
        prog[2] = 16'h0001;
        prog[3] = 16'hFFFF;

        reset = 1'b1; run = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        tick();
        tick();
        chk("rst_mode_run",  32'(mode_run),  32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data",  32'(rsp_data),  32'd0);
        chk("rst_rsp_err",   32'(rsp_err),   32'd0);
        chk("rst_ld_err",    32'(ld_err),    32'd0);
        reset = 1'b0;

        // Load program words 0..3.
        for (int i = 0; i < 4; i++) begin
            ld_en = 1'b1; ld_addr = 16'(i); ld_data = prog[i];
            tick();
            chk("load_ld_err", 32'(ld_err), 32'd0);
        end
        ld_en = 1'b0;

        // Out-of-range load in LOAD mode: pulse, nothing written (would alias onto word 0).
        ld_en = 1'b1; ld_addr = 16'h0400; ld_data = 16'hDEAD;
        tick();
        ld_en = 1'b0;
        chk("oor_load_err", 32'(ld_err), 32'd1);
        chk("load_no_ready", 32'(req_ready), 32'd0);
        tick();
        chk("oor_load_err_pulse", 32'(ld_err), 32'd0);

        // Enter RUN.
        run = 1'b1;
        tick();
        chk("run_mode", 32'(mode_run), 32'd1);
        chk("run_ready", 32'(req_ready), 32'd1);
        chk("run_empty", 32'(rsp_valid), 32'd0);

        // Back-to-back fetch of 0..3 with consumer always ready.
        rsp_ready = 1'b1; req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_addr = 16'(i);
            tick();
            chk("b2b_valid", 32'(rsp_valid), 32'd1);
            chk("b2b_data",  32'(rsp_data),  32'(prog[i]));
            chk("b2b_ready", 32'(req_ready), 32'd1);
        end
        req_valid = 1'b0;
        tick();
        chk("b2b_drained_valid", 32'(rsp_valid), 32'd0);
        chk("b2b_drained_data",  32'(rsp_data),  32'd0);

        // Out-of-range fetch returns an error response with zero data.
        req_valid = 1'b1; req_addr = 16'h0400;
        tick();
        req_valid = 1'b0;
        chk("oor_fetch_valid", 32'(rsp_valid), 32'd1);
        chk("oor_fetch_err",   32'(rsp_err),   32'd1);
        chk("oor_fetch_data",  32'(rsp_data),  32'd0);
        tick();
        chk("oor_fetch_pop", 32'(rsp_valid), 32'd0);
        chk("oor_fetch_err_clr", 32'(rsp_err), 32'd0);

        // Load attempt in RUN is rejected; word 0 still reads F00F.
        ld_en = 1'b1; ld_addr = 16'h0000; ld_data = 16'h0000;
        tick();
        ld_en = 1'b0;
        chk("run_load_err", 32'(ld_err), 32'd1);
        req_valid = 1'b1; req_addr = 16'h0000;
        tick();
        req_valid = 1'b0;
        chk("run_load_err_pulse", 32'(ld_err), 32'd0);
        chk("run_load_mem0", 32'(rsp_data), 32'hF00F);
        tick();

        // Backpressure: two accepted, third waits until the head is popped.
        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 16'd0;
        tick();
        chk("bp_ready_after1", 32'(req_ready), 32'd1);
        req_addr = 16'd1;
        tick();
        chk("bp_ready_after2", 32'(req_ready), 32'd0);
        chk("bp_head", 32'(rsp_data), 32'hF00F);
        req_addr = 16'd2;
        tick();
        chk("bp_still_full", 32'(req_ready), 32'd0);
        chk("bp_head_hold", 32'(rsp_data), 32'hF00F);
        rsp_ready = 1'b1;
        tick();
        chk("bp_pop1_data", 32'(rsp_data), 32'h1A2B);
        chk("bp_pop1_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        chk("bp_third_valid", 32'(rsp_valid), 32'd1);
        chk("bp_third_data", 32'(rsp_data), 32'h0001);
        tick();
        chk("bp_empty", 32'(rsp_valid), 32'd0);

        // Drain: leave RUN with two responses queued.
        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 16'd3;
        tick();
        req_addr = 16'd1;
        tick();
        req_valid = 1'b0;
        run = 1'b0;
        tick();
        chk("drain_mode", 32'(mode_run), 32'd0);
        chk("drain_ready", 32'(req_ready), 32'd0);
        chk("drain_head", 32'(rsp_data), 32'hFFFF);
        ld_en = 1'b1; ld_addr = 16'd5; ld_data = 16'h5555;
        tick();
        ld_en = 1'b0;
        chk("drain_load_rejected", 32'(ld_err), 32'd1);
        rsp_ready = 1'b1;
        tick();
        chk("drain_pop1", 32'(rsp_data), 32'h1A2B);
        ld_en = 1'b1; ld_addr = 16'd5; ld_data = 16'h5555;
        tick();
        ld_en = 1'b0;
        chk("drain_one_left_rejected", 32'(ld_err), 32'd1);
        chk("drain_empty", 32'(rsp_valid), 32'd0);
        tick();
        ld_en = 1'b1; ld_addr = 16'd5; ld_data = 16'h1234;
        tick();
        ld_en = 1'b0;
        chk("load_after_drain", 32'(ld_err), 32'd0);
        chk("load_after_drain_mode", 32'(mode_run), 32'd0);

        // Reset with two queued responses and a pending bad load.
        run = 1'b1;
        tick();
        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 16'd5;
        tick();
        req_addr = 16'd2;
        tick();
        req_valid = 1'b0;
        chk("pre_rst_head", 32'(rsp_data), 32'h1234);
        reset = 1'b1; ld_en = 1'b1; ld_addr = 16'h0400;
        tick();
        reset = 1'b0; ld_en = 1'b0;
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_data", 32'(rsp_data), 32'd0);
        chk("mid_rst_mode", 32'(mode_run), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_ld_err", 32'(ld_err), 32'd0);
        tick();
        chk("post_rst_run", 32'(mode_run), 32'd1);
        rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 16'd1;
        tick();
        req_valid = 1'b0;
        chk("post_rst_mem1", 32'(rsp_data), 32'h1A2B);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
